// File: rtl/ddr_frame_burst_arbiter_pkg.sv
// Shared types and helpers for the DDR frame burst arbiter.
package ddr_frame_burst_arbiter_pkg;

  // Arbiter states: idle, or waiting for the controller to finish a write or read burst.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    WR_WAIT  = 2'd1,
    RD_WAIT  = 2'd2
  } arb_state_e;

  localparam logic [9:0]  DEF_BURST_LEN   = 10'd128;
  localparam logic [24:0] DEF_FRAME_WORDS = 25'd153600;  // 640x480x16b packed in 32b words

  // Burst length: the smaller of the burst limit and the words left in the frame,
  // truncated to the 10-bit length field.
  function automatic logic [9:0] min_len(input logic [31:0] max_len,
                                         input logic [31:0] remaining);
    if (remaining < max_len) begin
      return remaining[9:0];
    end
    return max_len[9:0];
  endfunction

endpackage

// File: rtl/ddr_frame_burst_arbiter_ptr.sv
// Frame address pointer for one direction: holds the word offset into the frame,
// derives the next burst length, and advances/wraps when a burst finishes.
// A frame-start request that arrives while this side's burst is in flight is
// parked and replaces the advance once the burst finishes.
module frame_addr_ptr
  import ddr_frame_burst_arbiter_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 25,
  parameter logic [9:0]            BURST_LEN   = DEF_BURST_LEN,
  parameter logic [ADDR_WIDTH-1:0] FRAME_WORDS = ADDR_WIDTH'(DEF_FRAME_WORDS)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,       // restart the frame at offset 0
  input  logic                  busy_i,        // this side's burst is in flight
  input  logic                  finish_i,      // controller finished the burst
  output logic [ADDR_WIDTH-1:0] ptr_o,
  output logic [9:0]            len_o,
  output logic                  frame_done_o   // 1-cycle pulse after the last burst of a frame
);

  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] remaining;
  logic [ADDR_WIDTH-1:0] sum;
  logic                  pending_q, pending_d;
  logic                  done_q, done_d;

  // Words left in the frame; wraps to a large value if the pointer ever overshoots,
  // which simply selects the full burst length.
  assign remaining = FRAME_WORDS - ptr_q;
  assign len_o     = min_len(32'(BURST_LEN), 32'(remaining));
  assign sum       = ptr_q + ADDR_WIDTH'(len_o);

  // Next pointer: clear on start, advance or wrap on finish, park starts while busy.
  always_comb begin
    ptr_d     = ptr_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    if (busy_i) begin
      if (start_i) begin
        pending_d = 1'b1;
      end
      if (finish_i) begin
        pending_d = 1'b0;
        if (pending_q || start_i) begin
          ptr_d = '0;
        end else if (sum >= FRAME_WORDS) begin
          ptr_d  = '0;
          done_d = 1'b1;
        end else begin
          ptr_d = sum;
        end
      end
    end else if (start_i) begin
      ptr_d = '0;
    end
  end

  // Pointer, pending-start and frame-done registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q     <= '0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      pending_q <= pending_d;
      done_q    <= done_d;
    end
  end

  assign ptr_o        = ptr_q;
  assign frame_done_o = done_q;

endmodule

// File: rtl/ddr_frame_burst_arbiter.sv
// Turns camera write-FIFO and Ethernet read-FIFO levels into DDR burst requests,
// one burst at a time, with strict write priority so the camera never stalls.
module ddr_frame_burst_arbiter
  import ddr_frame_burst_arbiter_pkg::*;
#(
  parameter int                    MEM_DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH     = 25,
  parameter int                    FIFO_AW        = 10,
  parameter logic [9:0]            BURST_LEN      = DEF_BURST_LEN,
  parameter logic [ADDR_WIDTH-1:0] FRAME_WORDS    = ADDR_WIDTH'(DEF_FRAME_WORDS),
  parameter logic [ADDR_WIDTH-1:0] WR_BASE        = '0,
  parameter logic [ADDR_WIDTH-1:0] RD_BASE        = '0
) (
  input  logic                      MEM_CLK,
  input  logic                      RST_N,
  input  logic [FIFO_AW-1:0]        WR_FIFO_USEDW,
  output logic                      WR_FIFO_RDREQ,
  input  logic [MEM_DATA_WIDTH-1:0] WR_FIFO_Q,
  input  logic [FIFO_AW-1:0]        RD_FIFO_USEDW,
  output logic                      RD_FIFO_WRREQ,
  output logic [MEM_DATA_WIDTH-1:0] RD_FIFO_DATA,
  input  logic                      WR_FRAME_START,
  input  logic                      RD_FRAME_START,
  output logic                      WR_FRAME_DONE,
  output logic                      RD_FRAME_DONE,
  output logic                      FRAME_VALID,
  output logic                      WR_BURST_REQ,
  output logic [9:0]                WR_BURST_LEN,
  output logic [ADDR_WIDTH-1:0]     WR_BURST_ADDR,
  output logic [MEM_DATA_WIDTH-1:0] WR_BURST_DATA,
  input  logic                      WR_BURST_DATA_REQ,
  output logic                      RD_BURST_REQ,
  output logic [9:0]                RD_BURST_LEN,
  output logic [ADDR_WIDTH-1:0]     RD_BURST_ADDR,
  input  logic [MEM_DATA_WIDTH-1:0] RD_BURST_DATA,
  input  logic                      RD_BURST_DATA_VALID,
  input  logic                      WR_FINISH,
  input  logic                      RD_FINISH,
  input  logic                      BURST_IDLE
);

  arb_state_e            state_q, state_d;
  logic                  wr_req_q, wr_req_d;
  logic [9:0]            wr_len_q, wr_len_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic                  rd_req_q, rd_req_d;
  logic [9:0]            rd_len_q, rd_len_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  frame_valid_q;

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [9:0]            wr_len, rd_len;
  logic                  wr_done, rd_done;
  logic [FIFO_AW-1:0]    rd_free;
  logic                  wr_eligible, rd_eligible;

  frame_addr_ptr #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .BURST_LEN   (BURST_LEN),
    .FRAME_WORDS (FRAME_WORDS)
  ) u_wr_ptr (
    .clk_i        (MEM_CLK),
    .rst_ni       (RST_N),
    .start_i      (WR_FRAME_START),
    .busy_i       (state_q == WR_WAIT),
    .finish_i     (WR_FINISH),
    .ptr_o        (wr_ptr),
    .len_o        (wr_len),
    .frame_done_o (wr_done)
  );

  frame_addr_ptr #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .BURST_LEN   (BURST_LEN),
    .FRAME_WORDS (FRAME_WORDS)
  ) u_rd_ptr (
    .clk_i        (MEM_CLK),
    .rst_ni       (RST_N),
    .start_i      (RD_FRAME_START),
    .busy_i       (state_q == RD_WAIT),
    .finish_i     (RD_FINISH),
    .ptr_o        (rd_ptr),
    .len_o        (rd_len),
    .frame_done_o (rd_done)
  );

  // Write side needs a whole burst already buffered; read side needs room for a whole burst.
  assign rd_free     = {FIFO_AW{1'b1}} - RD_FIFO_USEDW;
  assign wr_eligible = 32'(WR_FIFO_USEDW) >= 32'(wr_len);
  assign rd_eligible = FRAME_VALID && (32'(rd_free) >= 32'(rd_len));

  // Arbitration FSM: launch one burst from idle, then wait for its finish.
  always_comb begin
    state_d   = state_q;
    wr_req_d  = 1'b0;
    wr_len_d  = wr_len_q;
    wr_addr_d = wr_addr_q;
    rd_req_d  = 1'b0;
    rd_len_d  = rd_len_q;
    rd_addr_d = rd_addr_q;
    case (state_q)
      ARB_IDLE: begin
        if (BURST_IDLE) begin
          if (wr_eligible) begin
            // A coinciding frame start moves the pointer first; the launch retries next cycle.
            if (!WR_FRAME_START) begin
              wr_req_d  = 1'b1;
              wr_len_d  = wr_len;
              wr_addr_d = WR_BASE + wr_ptr;
              state_d   = WR_WAIT;
            end
          end else if (rd_eligible && !RD_FRAME_START) begin
            rd_req_d  = 1'b1;
            rd_len_d  = rd_len;
            rd_addr_d = RD_BASE + rd_ptr;
            state_d   = RD_WAIT;
          end
        end
      end
      WR_WAIT: begin
        if (WR_FINISH) begin
          state_d = ARB_IDLE;
        end
      end
      RD_WAIT: begin
        if (RD_FINISH) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State and registered burst-request outputs; reset abandons any burst in flight.
  always_ff @(posedge MEM_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ARB_IDLE;
      wr_req_q  <= 1'b0;
      wr_len_q  <= '0;
      wr_addr_q <= '0;
      rd_req_q  <= 1'b0;
      rd_len_q  <= '0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_req_q  <= wr_req_d;
      wr_len_q  <= wr_len_d;
      wr_addr_q <= wr_addr_d;
      rd_req_q  <= rd_req_d;
      rd_len_q  <= rd_len_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  // Sticky flag: a complete frame has been written at least once.
  always_ff @(posedge MEM_CLK or negedge RST_N) begin
    if (!RST_N) begin
      frame_valid_q <= 1'b0;
    end else begin
      frame_valid_q <= frame_valid_q | wr_done;
    end
  end

  // OR in the done pulse so FRAME_VALID rises together with WR_FRAME_DONE.
  assign FRAME_VALID   = frame_valid_q | wr_done;
  assign WR_FRAME_DONE = wr_done;
  assign RD_FRAME_DONE = rd_done;

  assign WR_BURST_REQ  = wr_req_q;
  assign WR_BURST_LEN  = wr_len_q;
  assign WR_BURST_ADDR = wr_addr_q;
  assign RD_BURST_REQ  = rd_req_q;
  assign RD_BURST_LEN  = rd_len_q;
  assign RD_BURST_ADDR = rd_addr_q;

  // Data paths: strobes only pass while the matching burst is in flight.
  assign WR_FIFO_RDREQ = (state_q == WR_WAIT) && WR_BURST_DATA_REQ;
  assign WR_BURST_DATA = WR_FIFO_Q;
  assign RD_FIFO_WRREQ = (state_q == RD_WAIT) && RD_BURST_DATA_VALID;
  assign RD_FIFO_DATA  = RD_BURST_DATA;

endmodule

// File: tb/tb_ddr_frame_burst_arbiter.sv
// Directed bench for ddr_frame_burst_arbiter with a 300-word frame.
module tb_ddr_frame_burst_arbiter;

  localparam int WB = 1000;   // write base
  localparam int RB = 5000;   // read base

  logic        MEM_CLK = 1'b0;
  logic        RST_N;
  logic [9:0]  WR_FIFO_USEDW;
  logic        WR_FIFO_RDREQ;
  logic [31:0] WR_FIFO_Q;
  logic [9:0]  RD_FIFO_USEDW;
  logic        RD_FIFO_WRREQ;
  logic [31:0] RD_FIFO_DATA;
  logic        WR_FRAME_START;
  logic        RD_FRAME_START;
  logic        WR_FRAME_DONE;
  logic        RD_FRAME_DONE;
  logic        FRAME_VALID;
  logic        WR_BURST_REQ;
  logic [9:0]  WR_BURST_LEN;
  logic [24:0] WR_BURST_ADDR;
  logic [31:0] WR_BURST_DATA;
  logic        WR_BURST_DATA_REQ;
  logic        RD_BURST_REQ;
  logic [9:0]  RD_BURST_LEN;
  logic [24:0] RD_BURST_ADDR;
  logic [31:0] RD_BURST_DATA;
  logic        RD_BURST_DATA_VALID;
  logic        WR_FINISH;
  logic        RD_FINISH;
  logic        BURST_IDLE;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 MEM_CLK = ~MEM_CLK;

  ddr_frame_burst_arbiter #(
    .MEM_DATA_WIDTH (32),
    .ADDR_WIDTH     (25),
    .FIFO_AW        (10),
    .BURST_LEN      (10'd128),
    .FRAME_WORDS    (25'd300),
    .WR_BASE        (25'(WB)),
    .RD_BASE        (25'(RB))
  ) dut (
    .MEM_CLK             (MEM_CLK),
    .RST_N               (RST_N),
    .WR_FIFO_USEDW       (WR_FIFO_USEDW),
    .WR_FIFO_RDREQ       (WR_FIFO_RDREQ),
    .WR_FIFO_Q           (WR_FIFO_Q),
    .RD_FIFO_USEDW       (RD_FIFO_USEDW),
    .RD_FIFO_WRREQ       (RD_FIFO_WRREQ),
    .RD_FIFO_DATA        (RD_FIFO_DATA),
    .WR_FRAME_START      (WR_FRAME_START),
    .RD_FRAME_START      (RD_FRAME_START),
    .WR_FRAME_DONE       (WR_FRAME_DONE),
    .RD_FRAME_DONE       (RD_FRAME_DONE),
    .FRAME_VALID         (FRAME_VALID),
    .WR_BURST_REQ        (WR_BURST_REQ),
    .WR_BURST_LEN        (WR_BURST_LEN),
    .WR_BURST_ADDR       (WR_BURST_ADDR),
    .WR_BURST_DATA       (WR_BURST_DATA),
    .WR_BURST_DATA_REQ   (WR_BURST_DATA_REQ),
    .RD_BURST_REQ        (RD_BURST_REQ),
    .RD_BURST_LEN        (RD_BURST_LEN),
    .RD_BURST_ADDR       (RD_BURST_ADDR),
    .RD_BURST_DATA       (RD_BURST_DATA),
    .RD_BURST_DATA_VALID (RD_BURST_DATA_VALID),
    .WR_FINISH           (WR_FINISH),
    .RD_FINISH           (RD_FINISH),
    .BURST_IDLE          (BURST_IDLE)
  );

  typedef struct {
    logic [9:0]  wr_u;
    logic [9:0]  rd_u;
    logic        idle;
    logic        wf;
    logic        rf;
    logic        wreq;
    logic [9:0]  wlen;
    logic [24:0] waddr;
    logic        rreq;
    logic [9:0]  rlen;
    logic [24:0] raddr;
    logic        wdone;
    logic        fv;
  } vec_t;

  vec_t tab[18];

  function automatic vec_t mk(input int wu, input int ru, input int id, input int wf,
                              input int rf, input int wq, input int wl, input int wa,
                              input int rq, input int rl, input int ra, input int wd,
                              input int fv);
    vec_t v;
    v.wr_u = 10'(wu); v.rd_u = 10'(ru); v.idle = 1'(id); v.wf = 1'(wf); v.rf = 1'(rf);
    v.wreq = 1'(wq); v.wlen = 10'(wl); v.waddr = 25'(wa);
    v.rreq = 1'(rq); v.rlen = 10'(rl); v.raddr = 25'(ra);
    v.wdone = 1'(wd); v.fv = 1'(fv);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge MEM_CLK);
    #1;
  endtask

  initial begin
    int pulses;
    // Table: inputs applied for one clock, registered outputs checked 1ns after the edge.
    //            wr_u  rd_u id wf rf  wreq wlen waddr    rreq rlen raddr    wdone fv
    tab[0]  = mk(   0,    0, 1, 0, 0,  0,   0,   0,       0,   0,   0,       0, 0); // nothing buffered, no frame yet
    tab[1]  = mk( 200,    0, 0, 0, 0,  0,   0,   0,       0,   0,   0,       0, 0); // controller busy: hold
    tab[2]  = mk( 200,    0, 1, 0, 0,  1, 128,   WB,      0,   0,   0,       0, 0); // first write burst
    tab[3]  = mk( 200,    0, 1, 0, 0,  0, 128,   WB,      0,   0,   0,       0, 0); // pulse ends, len/addr held
    tab[4]  = mk( 200,    0, 1, 1, 0,  0, 128,   WB,      0,   0,   0,       0, 0); // finish
    tab[5]  = mk( 200,    0, 1, 0, 0,  1, 128,   WB+128,  0,   0,   0,       0, 0);
    tab[6]  = mk( 200,    0, 1, 1, 0,  0, 128,   WB+128,  0,   0,   0,       0, 0);
    tab[7]  = mk( 200,    0, 1, 0, 0,  1,  44,   WB+256,  0,   0,   0,       0, 0); // frame tail
    tab[8]  = mk( 200,    0, 1, 1, 0,  0,  44,   WB+256,  0,   0,   0,       1, 1); // wrap, frame done
    tab[9]  = mk( 200, 1000, 1, 0, 0,  1, 128,   WB,      0,   0,   0,       0, 1); // wrapped to base
    tab[10] = mk( 200, 1000, 1, 1, 0,  0, 128,   WB,      0,   0,   0,       0, 1);
    tab[11] = mk(   0, 1000, 1, 0, 0,  0, 128,   WB,      0,   0,   0,       0, 1); // read FIFO too full
    tab[12] = mk(   0,  800, 1, 0, 0,  0, 128,   WB,      1, 128,   RB,      0, 1); // room: read launch
    tab[13] = mk( 200,  800, 1, 0, 1,  0, 128,   WB,      0, 128,   RB,      0, 1); // read finish
    tab[14] = mk( 200,  800, 1, 0, 0,  1, 128,   WB+128,  0, 128,   RB,      0, 1); // both eligible: write wins
    tab[15] = mk(  10,  800, 1, 1, 0,  0, 128,   WB+128,  0, 128,   RB,      0, 1);
    tab[16] = mk(  10,  800, 1, 0, 0,  0, 128,   WB+128,  1, 128,   RB+128,  0, 1); // 10 < 44: read goes
    tab[17] = mk(  10,  800, 1, 0, 1,  0, 128,   WB+128,  0, 128,   RB+128,  0, 1);

    RST_N = 1'b0;
    WR_FIFO_USEDW = '0; WR_FIFO_Q = '0; RD_FIFO_USEDW = '0;
    WR_FRAME_START = 1'b0; RD_FRAME_START = 1'b0; WR_BURST_DATA_REQ = 1'b0;
    RD_BURST_DATA = '0; RD_BURST_DATA_VALID = 1'b0;
    WR_FINISH = 1'b0; RD_FINISH = 1'b0; BURST_IDLE = 1'b0;
    repeat (3) tick();
    chk("reset wr_req", 32'(WR_BURST_REQ), 0);
    chk("reset wr_addr", 32'(WR_BURST_ADDR), 0);
    chk("reset rd_req", 32'(RD_BURST_REQ), 0);
    chk("reset frame_valid", 32'(FRAME_VALID), 0);
    chk("reset wr_done", 32'(WR_FRAME_DONE), 0);
    RST_N = 1'b1;

    for (int i = 0; i < 18; i++) begin
      WR_FIFO_USEDW = tab[i].wr_u;
      RD_FIFO_USEDW = tab[i].rd_u;
      BURST_IDLE    = tab[i].idle;
      WR_FINISH     = tab[i].wf;
      RD_FINISH     = tab[i].rf;
      tick();
      chk($sformatf("v%0d wr_req", i), 32'(WR_BURST_REQ), 32'(tab[i].wreq));
      chk($sformatf("v%0d wr_len", i), 32'(WR_BURST_LEN), 32'(tab[i].wlen));
      chk($sformatf("v%0d wr_addr", i), 32'(WR_BURST_ADDR), 32'(tab[i].waddr));
      chk($sformatf("v%0d rd_req", i), 32'(RD_BURST_REQ), 32'(tab[i].rreq));
      chk($sformatf("v%0d rd_len", i), 32'(RD_BURST_LEN), 32'(tab[i].rlen));
      chk($sformatf("v%0d rd_addr", i), 32'(RD_BURST_ADDR), 32'(tab[i].raddr));
      chk($sformatf("v%0d wr_done", i), 32'(WR_FRAME_DONE), 32'(tab[i].wdone));
      chk($sformatf("v%0d frame_valid", i), 32'(FRAME_VALID), 32'(tab[i].fv));
    end
    WR_FINISH = 1'b0; RD_FINISH = 1'b0;

    // Read tail burst (rd_ptr 256 -> 44 words); FIFO strobes mirror the valid pattern.
    WR_FIFO_USEDW = 0; RD_FIFO_USEDW = 800;
    tick();
    chk("rtail rd_req", 32'(RD_BURST_REQ), 1);
    chk("rtail rd_len", 32'(RD_BURST_LEN), 44);
    chk("rtail rd_addr", 32'(RD_BURST_ADDR), RB + 256);
    pulses = 0;
    for (int i = 0; i < 88; i++) begin
      RD_BURST_DATA_VALID = (i % 2 == 0);
      RD_BURST_DATA = 32'hA500_0000 + 32'(i);
      #1;
      chk($sformatf("rtail wrreq %0d", i), 32'(RD_FIFO_WRREQ), 32'(RD_BURST_DATA_VALID));
      if (RD_BURST_DATA_VALID) chk($sformatf("rtail data %0d", i), RD_FIFO_DATA, 32'hA500_0000 + 32'(i));
      if (RD_FIFO_WRREQ) pulses++;
      tick();
    end
    RD_BURST_DATA_VALID = 1'b0;
    chk("rtail pulse count", 32'(pulses), 44);
    RD_FINISH = 1'b1; RD_FIFO_USEDW = 1000;
    tick();
    RD_FINISH = 1'b0;
    chk("rtail rd_done pulse", 32'(RD_FRAME_DONE), 1);
    tick();
    chk("rtail rd_done end", 32'(RD_FRAME_DONE), 0);
    RD_BURST_DATA_VALID = 1'b1;
    #1;
    chk("idle wrreq gated", 32'(RD_FIFO_WRREQ), 0);
    RD_BURST_DATA_VALID = 1'b0;

    // Frame start during own write burst at wr_ptr 256: pointer restarts, no frame done.
    WR_FIFO_USEDW = 200;
    tick();
    chk("wstart wr_req", 32'(WR_BURST_REQ), 1);
    chk("wstart wr_addr", 32'(WR_BURST_ADDR), WB + 256);
    chk("wstart wr_len", 32'(WR_BURST_LEN), 44);
    WR_FRAME_START = 1'b1; WR_BURST_DATA_REQ = 1'b1; WR_FIFO_Q = 32'hDEAD_BEEF;
    #1;
    chk("wwait rdreq", 32'(WR_FIFO_RDREQ), 1);
    chk("wwait data", WR_BURST_DATA, 32'hDEAD_BEEF);
    tick();
    WR_FRAME_START = 1'b0; WR_BURST_DATA_REQ = 1'b0;
    WR_FINISH = 1'b1; WR_FIFO_USEDW = 0;
    tick();
    WR_FINISH = 1'b0;
    chk("wstart no done a", 32'(WR_FRAME_DONE), 0);
    WR_BURST_DATA_REQ = 1'b1;
    #1;
    chk("idle rdreq gated", 32'(WR_FIFO_RDREQ), 0);
    WR_BURST_DATA_REQ = 1'b0;
    tick();
    chk("wstart no done b", 32'(WR_FRAME_DONE), 0);
    WR_FIFO_USEDW = 200;
    tick();
    chk("wstart relaunch req", 32'(WR_BURST_REQ), 1);
    chk("wstart relaunch addr", 32'(WR_BURST_ADDR), WB);
    chk("wstart relaunch len", 32'(WR_BURST_LEN), 128);

    // Start coinciding with a launch in idle (wr_ptr 128): launch suppressed, pointer cleared.
    WR_FINISH = 1'b1; WR_FIFO_USEDW = 0;
    tick();
    WR_FINISH = 1'b0; WR_FIFO_USEDW = 200; WR_FRAME_START = 1'b1;
    tick();
    chk("coinc suppressed", 32'(WR_BURST_REQ), 0);
    WR_FRAME_START = 1'b0;
    tick();
    chk("coinc launch req", 32'(WR_BURST_REQ), 1);
    chk("coinc launch addr", 32'(WR_BURST_ADDR), WB);

    // Asynchronous reset in the middle of a write burst.
    WR_BURST_DATA_REQ = 1'b1;
    #2;
    RST_N = 1'b0;
    #1;
    chk("arst wr_len", 32'(WR_BURST_LEN), 0);
    chk("arst wr_addr", 32'(WR_BURST_ADDR), 0);
    chk("arst rd_len", 32'(RD_BURST_LEN), 0);
    chk("arst rd_addr", 32'(RD_BURST_ADDR), 0);
    chk("arst frame_valid", 32'(FRAME_VALID), 0);
    chk("arst rdreq", 32'(WR_FIFO_RDREQ), 0);
    WR_BURST_DATA_REQ = 1'b0;
    tick();
    RST_N = 1'b1; WR_FIFO_USEDW = 200; RD_FIFO_USEDW = 0;
    tick();
    chk("post-rst wr_req", 32'(WR_BURST_REQ), 1);
    chk("post-rst wr_addr", 32'(WR_BURST_ADDR), WB);
    WR_FINISH = 1'b1; WR_FIFO_USEDW = 0;
    tick();
    WR_FINISH = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("post-rst no read %0d", i), 32'(RD_BURST_REQ), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_frame_burst_arbiter.md
Name: ddr_frame_burst_arbiter

Overview:
Sits directly upstream of the DDR burst controller and turns FIFO traffic into burst requests. The write side drains the camera write FIFO into the DDR frame region. The read side fills the Ethernet read FIFO from the same region. It owns the frame address pointers, wrap-around and frame-done signalling, and arbitrates one burst at a time with write priority.

Parameters:
MEM_DATA_WIDTH, 32, data word width
ADDR_WIDTH, 25, DDR word address width
FIFO_AW, 10, FIFO used-word count width (FIFO depth 2^FIFO_AW)
BURST_LEN, 10'd128, maximum words per burst (must be ≤ 2^FIFO_AW − 1)
FRAME_WORDS, 25'd153600, words per frame (640x480x16b / 32b)
WR_BASE, 25'd0, frame region base address used by the write side
RD_BASE, 25'd0, frame region base address used by the read side

Ports:
MEM_CLK  in  1  clock
RST_N  in  1  async active-low reset
WR_FIFO_USEDW  in  FIFO_AW  write FIFO read-side level
WR_FIFO_RDREQ  out  1  write FIFO read strobe
WR_FIFO_Q  in  MEM_DATA_WIDTH  write FIFO data (1-cycle read latency)
RD_FIFO_USEDW  in  FIFO_AW  read FIFO write-side level
RD_FIFO_WRREQ  out  1  read FIFO write strobe
RD_FIFO_DATA  out  MEM_DATA_WIDTH  read FIFO data
WR_FRAME_START  in  1  pulse: restart write pointer
RD_FRAME_START  in  1  pulse: restart read pointer
WR_FRAME_DONE  out  1  pulse: last word of frame written
RD_FRAME_DONE  out  1  pulse: last word of frame read
FRAME_VALID  out  1  at least one full frame in DDR
WR_BURST_REQ / WR_BURST_LEN[9:0] / WR_BURST_ADDR[ADDR_WIDTH] / WR_BURST_DATA[MEM_DATA_WIDTH]  out  write burst request
WR_BURST_DATA_REQ  in  1  controller data pull
RD_BURST_REQ / RD_BURST_LEN[9:0] / RD_BURST_ADDR[ADDR_WIDTH]  out  read burst request
RD_BURST_DATA[MEM_DATA_WIDTH] / RD_BURST_DATA_VALID  in  read return
WR_FINISH / RD_FINISH / BURST_IDLE  in  1  controller status

Behaviour:
- Clocking and reset: single clock, MEM_CLK. Reset is asynchronous, active-low, on RST_N.
- Reset values: all outputs 0; pointers 0; FSM ARB_IDLE; FRAME_VALID 0. Reset mid-burst abandons the burst; no finish is awaited.
- FSM states: ARB_IDLE, WR_WAIT, RD_WAIT.
- ARB_IDLE requires BURST_IDLE=1 before any launch.
- Write launch, when WR_FIFO_USEDW ≥ wr_len:
  - wr_len = min(BURST_LEN, FRAME_WORDS − wr_ptr).
  - WR_BURST_REQ is a registered 1-cycle pulse; LEN/ADDR are registered and held stable until the finish.
  - ADDR = WR_BASE + wr_ptr. Go to WR_WAIT.
- Read launch, only if no write launch is possible, and FRAME_VALID=1 and (2^FIFO_AW − 1 − RD_FIFO_USEDW) ≥ rd_len:
  - rd_len = min(BURST_LEN, FRAME_WORDS − rd_ptr); ADDR = RD_BASE + rd_ptr.
  - RD_BURST_REQ 1-cycle pulse; go to RD_WAIT.
- Write priority is strict: the camera source cannot stall.
- WR_WAIT:
  - WR_FIFO_RDREQ = WR_BURST_DATA_REQ (combinational, gated by state).
  - WR_BURST_DATA = WR_FIFO_Q pass-through.
  - On WR_FINISH: wr_ptr += wr_len. If the result equals FRAME_WORDS, wrap wr_ptr to 0, pulse WR_FRAME_DONE for 1 cycle, and set FRAME_VALID (sticky). Return to ARB_IDLE.
- RD_WAIT:
  - RD_FIFO_WRREQ = RD_BURST_DATA_VALID (gated by state); RD_FIFO_DATA = RD_BURST_DATA.
  - On RD_FINISH: rd_ptr += rd_len, with the same wrap rule; pulse RD_FRAME_DONE. Return to ARB_IDLE.
- WR_FRAME_START / RD_FRAME_START:
  - In ARB_IDLE (or the other side's WAIT state), the matching pointer clears to 0 on the next edge.
  - During its own WAIT state, the start is latched as pending and applied after the finish, overriding the increment. No frame-done pulse is generated in that case.
  - Start coincident with a launch: the start wins and the launch is suppressed for that cycle.
- Pointer arithmetic is ADDR_WIDTH unsigned; the compare for wrap is "≥ FRAME_WORDS", so bad parameters still wrap. Length math is truncated to 10 bits.
- Write bursts of 1 word are legal (frame tail).
- BURST_IDLE low in ARB_IDLE (e.g. controller init not done): hold, issue nothing.

Decomposition:
- Shared package: FSM state encodings, the BURST_LEN/FRAME_WORDS defaults, and a min-length function.
- One natural sub-module, frame_addr_ptr, instantiated twice (write and read). It holds the pointer, computes len, and handles advance-on-finish, wrap, frame-done and pending start.

Test Plan:
- WR_FIFO_USEDW=200, BURST_IDLE=1 -> WR_BURST_REQ 1 cycle, LEN=128, ADDR=0. After WR_FINISH: wr_ptr=128, next burst ADDR=128.
- FRAME_WORDS=300, continuous data -> bursts of 128, 128, 44. WR_FRAME_DONE pulse after the third finish; next ADDR=0; FRAME_VALID=1.
- Write and read both eligible in the same cycle -> write issued first; read issued after WR_FINISH. Before FRAME_VALID, no RD_BURST_REQ is ever issued.
- RD_FIFO_USEDW=1000 (free=23 < 128) -> no read request. Level drops to 800 -> RD_BURST_REQ, and 128 RD_FIFO_WRREQ pulses mirror RD_BURST_DATA_VALID.
- WR_FRAME_START during WR_WAIT at wr_ptr=256 -> burst completes; wr_ptr=0 (not 384); no WR_FRAME_DONE.
- RST_N low mid-WR_WAIT -> all outputs 0 asynchronously; after release, first burst ADDR=WR_BASE.
